// File: rtl/alu_mdu_ctrl_if.sv
// Execute-stage bundle between the pipeline (master) and the ALU decode / multiply-divide unit (slave).
interface alu_mdu_ctrl_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic            flush_i;
   logic            opb5;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic            funct7b0;
   logic [1:0]      ALUOp;
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] srcb;
   logic [3:0]      ALUControl;
   logic            mdu_busy;
   logic            mdu_done;
   logic [XLEN-1:0] mdu_result;

   modport master (
      output valid_i, flush_i, opb5, funct3, funct7b5, funct7b0, ALUOp, srca, srcb,
      input  ALUControl, mdu_busy, mdu_done, mdu_result
   );

   modport slave (
      input  valid_i, flush_i, opb5, funct3, funct7b5, funct7b0, ALUOp, srca, srcb,
      output ALUControl, mdu_busy, mdu_done, mdu_result
   );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus iterative multiply/restoring divide; result XLEN+1 cycles after start (2 for fast MUL).
// mdu_busy stalls the pipeline from the start cycle until DONE; flush or reset aborts silently.
`ifndef ALU_SUM
`define ALU_SUM  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLT  4'd5
`define ALU_SLTU 4'd6
`define ALU_SLL  4'd7
`define ALU_SRL  4'd8
`define ALU_SRA  4'd9
`define ALU_ROR  4'd10
`endif

module alu_mdu_ctrl #(
   parameter int XLEN     = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input logic           clk,
   input logic           reset,
   alu_mdu_ctrl_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state, nxt;
   logic              is_m, start, cnt_last, step_last, finish;
   logic [CW-1:0]     cnt;
   logic [2:0]        f3;
   logic              neg;
   logic [XLEN-1:0]   op;
   logic [2*XLEN-1:0] acc, acc_nxt, prod;
   logic              a_sgn, b_sgn, sa, sb, neg_in;
   logic [XLEN-1:0]   mag_a, mag_b, dval, fin;
   logic [XLEN:0]     sum, diff;

   always_comb begin
      is_m = bus.valid_i & (bus.ALUOp == 2'b10) & bus.opb5 & bus.funct7b0 & ~bus.funct7b5;
      bus.ALUControl = `ALU_SUM;
      if (!is_m) begin
         case (bus.ALUOp)
            2'b00: bus.ALUControl = `ALU_SUM;
            2'b01: bus.ALUControl = `ALU_SUB;
            default: begin
               case (bus.funct3)
                  3'b000:  bus.ALUControl = (bus.funct7b5 & bus.opb5) ? `ALU_SUB : `ALU_SUM;
                  3'b001:  bus.ALUControl = bus.funct7b5 ? `ALU_ROR : `ALU_SLL;
                  3'b010:  bus.ALUControl = `ALU_SLT;
                  3'b011:  bus.ALUControl = `ALU_SLTU;
                  3'b100:  bus.ALUControl = `ALU_XOR;
                  3'b101:  bus.ALUControl = bus.funct7b5 ? `ALU_SRA : `ALU_SRL;
                  3'b110:  bus.ALUControl = `ALU_OR;
                  default: bus.ALUControl = `ALU_AND;
               endcase
            end
         endcase
      end
   end

   // Signed ops run on magnitudes; neg records whether the final value must be negated.
   always_comb begin
      a_sgn = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
      b_sgn = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
      sa    = a_sgn & bus.srca[XLEN-1];
      sb    = b_sgn & bus.srcb[XLEN-1];
      mag_a = sa ? -bus.srca : bus.srca;
      mag_b = sb ? -bus.srcb : bus.srcb;
      // Divide-by-zero must return an unnegated all-ones quotient.
      if (bus.funct3[2])
         neg_in = bus.funct3[1] ? sa : ((sa ^ sb) & (|bus.srcb));
      else
         neg_in = sa ^ sb;
   end

   always_comb begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op} : '0);
      diff    = acc[2*XLEN-1:XLEN-1] - {1'b0, op};
      acc_nxt = acc;
      if (state == MUL) begin
         if (FAST_MUL)
            acc_nxt = {{XLEN{1'b0}}, op} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
         else
            acc_nxt = {sum, acc[XLEN-1:1]};
      end else if (state == DIV) begin
         if (diff[XLEN])
            acc_nxt = {acc[2*XLEN-2:0], 1'b0};
         else
            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
      prod = neg ? -acc_nxt : acc_nxt;
      dval = f3[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
      if (state == DIV)
         fin = neg ? -dval : dval;
      else
         fin = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      start     = (state == IDLE) & is_m & ~bus.flush_i;
      cnt_last  = (cnt == CW'(XLEN-1));
      step_last = ((state == MUL) && FAST_MUL) ? 1'b1 : cnt_last;
      finish    = ((state == MUL) || (state == DIV)) & step_last & ~bus.flush_i;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = bus.funct3[2] ? DIV : MUL;
         MUL, DIV: begin
            if (bus.flush_i)
               nxt = IDLE;
            else if (step_last)
               nxt = DONE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mdu_busy = ~reset & (start | (state == MUL) | (state == DIV));
      bus.mdu_done = ~reset & (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= '0;
         f3             <= '0;
         neg            <= 1'b0;
         op             <= '0;
         acc            <= '0;
         bus.mdu_result <= '0;
      end else begin
         if (start) begin
            cnt <= '0;
            f3  <= bus.funct3;
            neg <= neg_in;
            // Multiply: op = multiplicand, acc low = multiplier. Divide: op = divisor, acc low = dividend.
            if (bus.funct3[2]) begin
               op  <= mag_b;
               acc <= {{XLEN{1'b0}}, mag_a};
            end else begin
               op  <= mag_a;
               acc <= {{XLEN{1'b0}}, mag_b};
            end
         end else if (state == MUL || state == DIV) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
         end
         if (finish)
            bus.mdu_result <= fin;
      end
   end
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: ALU decode vectors, M-extension ops via a scoreboard, flush and reset aborts.
module tb_alu_mdu_ctrl;
   localparam logic [3:0] A_SUM = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                          A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9,
                          A_ROR = 4'd10;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t qs[$];
   exp_t qf[$];
   exp_t es, ef;
   logic [31:0] last_s;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_mdu_ctrl_if #(.XLEN(32)) bs();
   alu_mdu_ctrl_if #(.XLEN(32)) bf();

   alu_mdu_ctrl #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (.clk(clk), .reset(reset), .bus(bs.slave));
   alu_mdu_ctrl #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (.clk(clk), .reset(reset), .bus(bf.slave));

   // Monitors: every done pulse must match the oldest outstanding expectation, value and cycle.
   always @(negedge clk) begin
      if (bs.mdu_done) begin
         checks++;
         if (qs.size() == 0) begin
            errors++;
            $display("FAIL slow_unexpected_done: result %h at cycle %0d with nothing outstanding", bs.mdu_result, cyc);
         end else begin
            es = qs.pop_front();
            if (bs.mdu_result !== es.res || cyc != es.due) begin
               errors++;
               $display("FAIL slow_done: got %h at cycle %0d, expected %h at cycle %0d", bs.mdu_result, cyc, es.res, es.due);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bf.mdu_done) begin
         checks++;
         if (qf.size() == 0) begin
            errors++;
            $display("FAIL fast_unexpected_done: result %h at cycle %0d with nothing outstanding", bf.mdu_result, cyc);
         end else begin
            ef = qf.pop_front();
            if (bf.mdu_result !== ef.res || cyc != ef.due) begin
               errors++;
               $display("FAIL fast_done: got %h at cycle %0d, expected %h at cycle %0d", bf.mdu_result, cyc, ef.res, ef.due);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit fast, input bit v, input bit fl, input logic [1:0] aop,
                        input logic [2:0] f3, input bit f7b5, input bit ob5, input bit f7b0,
                        input logic [31:0] a, input logic [31:0] b);
      if (fast) begin
         bf.valid_i = v; bf.flush_i = fl; bf.ALUOp = aop; bf.funct3 = f3;
         bf.funct7b5 = f7b5; bf.opb5 = ob5; bf.funct7b0 = f7b0; bf.srca = a; bf.srcb = b;
      end else begin
         bs.valid_i = v; bs.flush_i = fl; bs.ALUOp = aop; bs.funct3 = f3;
         bs.funct7b5 = f7b5; bs.opb5 = ob5; bs.funct7b0 = f7b0; bs.srca = a; bs.srcb = b;
      end
   endtask

   task automatic idle_all();
      drive(1'b0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 32'h0, 32'h0);
      drive(1'b1, 0, 0, 2'b00, 3'b000, 0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic dec(input logic [1:0] aop, input logic [2:0] f3, input bit f7b5, input bit ob5,
                      input bit f7b0, input bit v, input logic [3:0] exp);
      @(posedge clk); #1;
      drive(1'b0, v, 0, aop, f3, f7b5, ob5, f7b0, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("alu_ctrl op%b f3%b", aop, f3), {28'h0, bs.ALUControl}, {28'h0, exp});
      chk("alu_busy_low", {31'h0, bs.mdu_busy}, 32'h0);
   endtask

   // Holds the M-op like a stalled pipeline until done, then releases it.
   task automatic issue(input bit fast, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      exp_t e;
      bit   seen;
      @(posedge clk); #1;
      drive(fast, 1, 0, 2'b10, f3, 0, 1, 1, a, b);
      e.res = exp;
      e.due = cyc + ((fast && !f3[2]) ? 2 : 33);
      if (fast) qf.push_back(e); else qs.push_back(e);
      @(negedge clk);
      chk("busy_start", {31'h0, fast ? bf.mdu_busy : bs.mdu_busy}, 32'h1);
      chk("alu_m_sum", {28'h0, fast ? bf.ALUControl : bs.ALUControl}, {28'h0, A_SUM});
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = fast ? bf.mdu_done : bs.mdu_done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: f3 %b no done within 40 cycles", f3);
      end else begin
         chk("busy_in_done", {31'h0, fast ? bf.mdu_busy : bs.mdu_busy}, 32'h0);
         if (!fast) last_s = exp;
      end
      @(posedge clk); #1;
      drive(fast, 0, 0, 2'b00, 3'b000, 0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_all();
      // M-op presented while reset is held must not raise busy.
      drive(1'b0, 1, 0, 2'b10, 3'b000, 0, 1, 1, 32'h7, 32'h3);
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, bs.mdu_busy}, 32'h0);
      chk("rst_done", {31'h0, bs.mdu_done}, 32'h0);
      chk("rst_result", bs.mdu_result, 32'h0);
      chk("rst_alu_m", {28'h0, bs.ALUControl}, {28'h0, A_SUM});
      @(posedge clk); #1;
      idle_all();
      reset = 1'b0;
      last_s = 32'h0;

      dec(2'b00, 3'b101, 1, 1, 0, 1, A_SUM);
      dec(2'b01, 3'b000, 0, 0, 0, 1, A_SUB);
      dec(2'b10, 3'b000, 1, 1, 0, 1, A_SUB);
      dec(2'b10, 3'b000, 1, 0, 0, 1, A_SUM);
      dec(2'b10, 3'b001, 1, 1, 0, 1, A_ROR);
      dec(2'b10, 3'b001, 0, 1, 0, 1, A_SLL);
      dec(2'b10, 3'b010, 0, 1, 0, 1, A_SLT);
      dec(2'b10, 3'b011, 0, 1, 0, 1, A_SLTU);
      dec(2'b10, 3'b100, 0, 1, 0, 1, A_XOR);
      dec(2'b10, 3'b101, 1, 1, 0, 1, A_SRA);
      dec(2'b10, 3'b101, 0, 1, 0, 1, A_SRL);
      dec(2'b10, 3'b110, 0, 1, 0, 1, A_OR);
      dec(2'b10, 3'b111, 0, 1, 1, 0, A_AND);
      dec(2'b11, 3'b000, 1, 1, 0, 1, A_SUB);

      issue(1'b0, 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
      issue(1'b1, 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
      issue(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      issue(1'b0, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
      issue(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      issue(1'b1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
      issue(1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
      issue(1'b1, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
      issue(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      issue(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
      issue(1'b0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
      issue(1'b0, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
      issue(1'b0, 3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF);
      issue(1'b0, 3'b111, 32'h00000005, 32'h00000000, 32'h00000005);
      issue(1'b0, 3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF);
      issue(1'b0, 3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9);
      issue(1'b0, 3'b101, 32'd100, 32'd7, 32'd14);
      issue(1'b0, 3'b111, 32'd100, 32'd7, 32'd2);

      // Flush mid-DIV: back to IDLE next cycle, no done, result held.
      @(posedge clk); #1;
      drive(1'b0, 1, 0, 2'b10, 3'b100, 0, 1, 1, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1;
      drive(1'b0, 1, 1, 2'b10, 3'b100, 0, 1, 1, 32'd100, 32'd7);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk("flush_idle_busy", {31'h0, bs.mdu_busy}, 32'h0);
      chk("flush_result_hold", bs.mdu_result, last_s);
      repeat (40) @(negedge clk);
      chk("flush_result_hold_late", bs.mdu_result, last_s);

      // Flush together with a new M-op in IDLE: no start.
      @(posedge clk); #1;
      drive(1'b0, 1, 1, 2'b10, 3'b000, 0, 1, 1, 32'h3, 32'h3);
      @(negedge clk);
      chk("flush_start_busy", {31'h0, bs.mdu_busy}, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk("flush_no_start", {31'h0, bs.mdu_busy}, 32'h0);
      repeat (40) @(negedge clk);

      // Reset at N+10 of a MUL: everything cleared, no done pulse.
      @(posedge clk); #1;
      drive(1'b0, 1, 0, 2'b10, 3'b000, 0, 1, 1, 32'h7, 32'h9);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rst_mid_busy", {31'h0, bs.mdu_busy}, 32'h0);
      chk("rst_mid_done", {31'h0, bs.mdu_done}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_after_result", bs.mdu_result, 32'h0);
      chk("rst_after_done", {31'h0, bs.mdu_done}, 32'h0);
      chk("rst_after_busy", {31'h0, bs.mdu_busy}, 32'h0);
      chk("rst_after_alu", {28'h0, bs.ALUControl}, {28'h0, A_SUM});
      repeat (40) @(negedge clk);

      chk("scoreboard_drained", qs.size() + qf.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
